// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between two requesters:
//   requester 0 - core memory stage
//   requester 1 - program loader / debug port
// One access is in flight at a time. Each access follows the sequence
// IDLE -> ACCESS -> RESP. Accesses whose address is out of range skip
// ACCESS and go directly to RESP with err set.
//
// Ports
//   clk, reset           clock (rising edge); asynchronous active-high reset
//   req[1:0], we[1:0]    per-requester request / write enable (1 = write)
//   addr0/1, wdata0/1    per-requester byte address and write data
//   gnt[1:0]             one-hot, one-cycle pulse naming the accepted requester
//   done[1:0]            one-hot, one-cycle pulse marking completion
//   rdata, err           read data / error status, valid while done is high
//   mem_reEn, mem_wrEn   memory read / write enables (high only in ACCESS)
//   mem_addr             memory address (zero outside ACCESS)
//   mem_val_write        memory write data (zero outside ACCESS)
//   mem_val_read         memory read data
//   mem_error            memory-reported error
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,    // 1..15
    parameter int unsigned MEM_BYTES   = 1024,
    parameter bit          RR_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [63:0] addr0,
    input  logic [63:0] addr1,
    input  logic [63:0] wdata0,
    input  logic [63:0] wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [63:0] rdata,
    output logic        err,
    output logic        mem_reEn,
    output logic        mem_wrEn,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_val_write,
    input  logic [63:0] mem_val_read,
    input  logic        mem_error
);

    localparam int          DATA_W   = 64;
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);
    localparam logic [3:0]  CNT_INIT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rr_last_q, rr_last_d;
    logic                win_q, win_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                win;
    logic [DATA_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Round-robin: on contention the requester that did not win last time
    // goes next. Fixed priority: requester 0 wins whenever it is asking.
    function automatic logic pick_winner(input logic [1:0] r, input logic last);
        if (RR_EN) begin
            if (r == 2'b11) return ~last;
            return r[1];
        end
        return ~r[0];
    endfunction

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    assign win       = pick_winner(req, rr_last_q);
    assign sel_addr  = win ? addr1 : addr0;
    assign sel_wdata = win ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_last_q <= 1'b1;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        rdata_d   = rdata_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_d     = onehot(win);
                    rr_last_d = win;
                    win_d     = win;
                    we_d      = we[win];
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    if (sel_addr > MAX_ADDR) begin
                        // Rejected without touching memory; done coincides with gnt.
                        state_d = RESP;
                        done_d  = onehot(win);
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    done_d  = onehot(win_q);
                    rdata_d = we_q ? '0 : mem_val_read;
                    err_d   = mem_error;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Enables decode straight from the state register so an asynchronous
    // reset drops them without waiting for a clock edge.
    assign mem_reEn      = (state_q == ACCESS) && !we_q;
    assign mem_wrEn      = (state_q == ACCESS) && we_q;
    assign mem_addr      = (state_q == ACCESS) ? addr_q : '0;
    assign mem_val_write = (state_q == ACCESS) ? wdata_q : '0;

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Three arbiter instances with independent stimulus:
//   u_a : MEM_LATENCY=1, RR_EN=1
//   u_b : MEM_LATENCY=3, RR_EN=0
//   u_c : MEM_LATENCY=4, RR_EN=1
// Expected completions are queued per instance when a request is driven
// and popped whenever that instance pulses done.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [3];
    logic [1:0]  req    [3];
    logic [1:0]  we     [3];
    logic [63:0] addr0  [3];
    logic [63:0] addr1  [3];
    logic [63:0] wdata0 [3];
    logic [63:0] wdata1 [3];
    logic [63:0] mrd    [3];
    logic        merr   [3];

    logic [1:0]  gnt    [3];
    logic [1:0]  done   [3];
    logic [63:0] rdata  [3];
    logic        err    [3];
    logic        mre    [3];
    logic        mwe    [3];
    logic [63:0] maddr  [3];
    logic [63:0] mwv    [3];

    dmem_arbiter #(.MEM_LATENCY(1), .MEM_BYTES(1024), .RR_EN(1'b1)) u_a (
        .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]),
        .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .gnt(gnt[0]), .done(done[0]), .rdata(rdata[0]), .err(err[0]),
        .mem_reEn(mre[0]), .mem_wrEn(mwe[0]), .mem_addr(maddr[0]),
        .mem_val_write(mwv[0]), .mem_val_read(mrd[0]), .mem_error(merr[0])
    );

    dmem_arbiter #(.MEM_LATENCY(3), .MEM_BYTES(1024), .RR_EN(1'b0)) u_b (
        .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]),
        .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .gnt(gnt[1]), .done(done[1]), .rdata(rdata[1]), .err(err[1]),
        .mem_reEn(mre[1]), .mem_wrEn(mwe[1]), .mem_addr(maddr[1]),
        .mem_val_write(mwv[1]), .mem_val_read(mrd[1]), .mem_error(merr[1])
    );

    dmem_arbiter #(.MEM_LATENCY(4), .MEM_BYTES(1024), .RR_EN(1'b1)) u_c (
        .clk(clk), .reset(rst[2]), .req(req[2]), .we(we[2]),
        .addr0(addr0[2]), .addr1(addr1[2]), .wdata0(wdata0[2]), .wdata1(wdata1[2]),
        .gnt(gnt[2]), .done(done[2]), .rdata(rdata[2]), .err(err[2]),
        .mem_reEn(mre[2]), .mem_wrEn(mwe[2]), .mem_addr(maddr[2]),
        .mem_val_write(mwv[2]), .mem_val_read(mrd[2]), .mem_error(merr[2])
    );

    typedef struct {
        logic [1:0]  d;
        logic [63:0] rd;
        logic        e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int tests = 0;
    int fails = 0;

    function automatic logic [1:0] onehot(input int r);
        return (r == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int i, input logic [1:0] d, input logic [63:0] rd, input logic e);
        exp_t x;
        x.d = d; x.rd = rd; x.e = e;
        case (i)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic mon(input int i);
        exp_t x;
        if (done[i] != 2'b00) begin
            if (qsize(i) == 0) begin
                chk($sformatf("u%0d unexpected done", i), 64'(done[i]), 64'd0);
            end else begin
                case (i)
                    0:       x = q0.pop_front();
                    1:       x = q1.pop_front();
                    default: x = q2.pop_front();
                endcase
                chk($sformatf("u%0d done", i), 64'(done[i]), 64'(x.d));
                chk($sformatf("u%0d rdata", i), rdata[i], x.rd);
                chk($sformatf("u%0d err", i), 64'(err[i]), 64'(x.e));
            end
            if (gnt[i] != 2'b00)
                chk($sformatf("u%0d gnt matches done", i), 64'(gnt[i]), 64'(done[i]));
        end
        if (mre[i])
            chk($sformatf("u%0d mem_wrEn low while reading", i), 64'(mwe[i]), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) mon(i);
    endtask

    // One complete transaction from a single requester; req is dropped in the
    // done cycle so the arbiter returns to IDLE without a new grant.
    task automatic txn(input int i, input int r, input logic w, input logic [63:0] a,
                       input logic [63:0] wd, input int lat, input logic [63:0] exp_rd,
                       input logic exp_err, input bit oor);
        logic [1:0] oh;
        int n, nre, nwe;
        oh     = onehot(r);
        req[i] = oh;
        we[i]  = w ? oh : 2'b00;
        if (r == 0) begin addr0[i] = a; wdata0[i] = wd; end
        else        begin addr1[i] = a; wdata1[i] = wd; end
        push(i, oh, exp_rd, exp_err);
        tick();
        n = 1; nre = 0; nwe = 0;
        chk($sformatf("u%0d gnt a=%0h", i, a), 64'(gnt[i]), 64'(oh));
        if (!oor) begin
            chk($sformatf("u%0d mem_addr", i), maddr[i], a);
            if (w) chk($sformatf("u%0d mem_val_write", i), mwv[i], wd);
        end
        while (done[i] == 2'b00 && n < 40) begin
            nre += int'(mre[i]);
            nwe += int'(mwe[i]);
            tick();
            n++;
        end
        nre += int'(mre[i]);
        nwe += int'(mwe[i]);
        chk($sformatf("u%0d done latency a=%0h", i, a), 64'(n), oor ? 64'd1 : 64'(lat + 1));
        chk($sformatf("u%0d read-enable cycles", i), 64'(nre), (!w && !oor) ? 64'(lat) : 64'd0);
        chk($sformatf("u%0d write-enable cycles", i), 64'(nwe), (w && !oor) ? 64'(lat) : 64'd0);
        req[i] = 2'b00;
        we[i]  = 2'b00;
        tick();
        chk($sformatf("u%0d gnt idle", i), 64'(gnt[i]), 64'd0);
        chk($sformatf("u%0d done idle", i), 64'(done[i]), 64'd0);
        chk($sformatf("u%0d rdata held", i), rdata[i], exp_rd);
    endtask

    // Both requesters held high for four grants; expw[k] is the k-th winner.
    task automatic contend(input int i, input int lat, input logic [3:0] expw);
        int n, last, wn;
        req[i]   = 2'b11;
        we[i]    = 2'b00;
        addr0[i] = 64'h100;
        addr1[i] = 64'h108;
        for (int k = 0; k < 4; k++) push(i, onehot(int'(expw[k])), mrd[i], 1'b0);
        n = 0; last = 0;
        for (int k = 0; k < 4; k++) begin
            tick(); n++; wn = 1;
            while (gnt[i] == 2'b00 && wn < 40) begin tick(); n++; wn++; end
            chk($sformatf("u%0d contention grant %0d", i, k), 64'(gnt[i]),
                64'(onehot(int'(expw[k]))));
            if (k > 0)
                chk($sformatf("u%0d grant interval %0d", i, k), 64'(n - last), 64'(lat + 2));
            last = n;
        end
        wn = 0;
        while (done[i] == 2'b00 && wn < 40) begin tick(); wn++; end
        req[i] = 2'b00;
        tick();
        chk($sformatf("u%0d gnt after contention", i), 64'(gnt[i]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; req[i] = 2'b00; we[i] = 2'b00;
            addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
            mrd[i] = '0; merr[i] = 1'b0;
        end
        tick();
        tick();

        // Reset state
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d reset gnt", i), 64'(gnt[i]), 64'd0);
            chk($sformatf("u%0d reset done", i), 64'(done[i]), 64'd0);
            chk($sformatf("u%0d reset rdata", i), rdata[i], 64'd0);
            chk($sformatf("u%0d reset err", i), 64'(err[i]), 64'd0);
            chk($sformatf("u%0d reset mem_reEn", i), 64'(mre[i]), 64'd0);
            chk($sformatf("u%0d reset mem_wrEn", i), 64'(mwe[i]), 64'd0);
            chk($sformatf("u%0d reset mem_addr", i), maddr[i], 64'd0);
            chk($sformatf("u%0d reset mem_val_write", i), mwv[i], 64'd0);
            rst[i] = 1'b0;
        end
        tick();

        // u_a: single read, single write, round-robin contention, range check
        mrd[0] = 64'h1122334455667788;
        txn(0, 0, 1'b0, 64'h40, 64'h0, 1, 64'h1122334455667788, 1'b0, 1'b0);
        txn(0, 1, 1'b1, 64'h8, 64'hDEAD, 1, 64'h0, 1'b0, 1'b0);
        contend(0, 1, 4'b1010);
        txn(0, 0, 1'b0, 64'h3F9, 64'h0, 1, 64'h0, 1'b1, 1'b1);
        txn(0, 0, 1'b0, 64'h3F8, 64'h0, 1, 64'h1122334455667788, 1'b0, 1'b0);
        txn(0, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1, 64'h0, 1'b1, 1'b1);

        // u_b: fixed-priority contention, memory-reported error
        mrd[1] = 64'hA5A5_0000_1234_5678;
        contend(1, 3, 4'b0000);
        merr[1] = 1'b1;
        txn(1, 0, 1'b0, 64'h10, 64'h0, 3, 64'hA5A5_0000_1234_5678, 1'b1, 1'b0);
        merr[1] = 1'b0;

        // u_c: reset in the middle of an access
        mrd[2]    = 64'h0BAD_F00D_0000_0042;
        req[2]    = 2'b01;
        we[2]     = 2'b00;
        addr0[2]  = 64'h20;
        tick();
        chk("u2 gnt before abort", 64'(gnt[2]), 64'd1);
        chk("u2 mem_reEn after gnt", 64'(mre[2]), 64'd1);
        tick();
        tick();
        chk("u2 mem_reEn mid access", 64'(mre[2]), 64'd1);
        #2;
        rst[2] = 1'b1;
        #1;
        chk("u2 mem_reEn drops on async reset", 64'(mre[2]), 64'd0);
        chk("u2 mem_addr cleared on reset", maddr[2], 64'd0);
        req[2] = 2'b00;
        tick();
        tick();
        rst[2] = 1'b0;
        tick();
        chk("u2 no done after abort", 64'(done[2]), 64'd0);
        req[2] = 2'b11;
        push(2, 2'b01, 64'h0BAD_F00D_0000_0042, 1'b0);
        tick();
        chk("u2 first grant after reset", 64'(gnt[2]), 64'd1);
        begin
            int wn;
            wn = 0;
            while (done[2] == 2'b00 && wn < 40) begin tick(); wn++; end
        end
        req[2] = 2'b00;
        tick();

        chk("u0 scoreboard drained", 64'(q0.size()), 64'd0);
        chk("u1 scoreboard drained", 64'(q1.size()), 64'd0);
        chk("u2 scoreboard drained", 64'(q2.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates one single-port data memory between two requesters: requester 0 is the core memory stage, requester 1 is the program loader/debug port.
- Sits between those requesters and the data memory instance.
- Serialises accesses with a req/gnt/done handshake, sequences a fixed-latency memory access, range-checks addresses, and returns read data and error status.

Parameters:
- MEM_LATENCY, 1: cycles the memory needs from enable to valid mem_val_read/mem_error; legal range 1..15.
- MEM_BYTES, 1024: memory size in bytes; valid addresses are 0..MEM_BYTES-8.
- RR_EN, 1: 1 selects round-robin arbitration; 0 selects fixed priority with requester 0 winning.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  2  per-requester request; hold high with fields stable until done.
- we  input  2  per-requester write enable (1 = write, 0 = read).
- addr0, addr1  input  64 each  byte address of requester 0 / requester 1.
- wdata0, wdata1  input  64 each  write data of requester 0 / requester 1.
- gnt  output  2  one-hot, one-cycle pulse naming the accepted requester.
- done  output  2  one-hot, one-cycle pulse marking completion.
- rdata  output  64  read data, valid while done is high.
- err  output  1  error flag, valid while done is high.
- mem_reEn, mem_wrEn  output  1 each  memory read / write enable.
- mem_addr  output  64  memory address.
- mem_val_write  output  64  memory write data.
- mem_val_read  input  64  memory read data.
- mem_error  input  1  memory-reported error.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, rr_last=1 (so requester 0 is favoured first). gnt, done, rdata, err, mem_reEn, mem_wrEn, mem_addr and mem_val_write all 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If req!=0 at a rising edge: pick winner w.
  - Winner with RR_EN=1: if both requesters are high, w = ~rr_last; otherwise w is the single requester.
  - Winner with RR_EN=0: requester 0 always wins when high.
  - Latch we[w], addr_w and wdata_w internally; assert gnt[w] for exactly the next cycle; set rr_last=w.
  - If addr_w > MEM_BYTES-8: no memory enable is driven; go to RESP with err=1, rdata=0.
  - Otherwise: go to ACCESS and load cnt=MEM_LATENCY-1.
- ACCESS:
  - mem_addr and mem_val_write are driven from the latched fields.
  - Exactly one of mem_reEn (read) or mem_wrEn (write) is high for every ACCESS cycle; both are low in all other states.
  - Each cycle, cnt decrements.
  - When cnt==0 at an edge: capture rdata = read ? mem_val_read : 0, capture err = mem_error, go to RESP.
- RESP:
  - done[w] is high for one cycle, with rdata and err valid alongside it.
  - Next state is IDLE.
  - gnt is never issued in RESP.
  - rdata and err hold their value until the next RESP.
- Latency (requester sampled at edge E0):
  - gnt is high in cycle E0+1.
  - done is high in cycle E0+MEM_LATENCY+1.
  - Out-of-range access: done is high in cycle E0+1, the same cycle as gnt.
- Back-to-back operation: after RESP returns to IDLE, a new request is accepted at the next edge. Minimum issue interval is MEM_LATENCY+2 cycles.
- Outputs: gnt and done are registered, one-hot or zero, and never both set for different requesters in the same cycle.
- Request dropped after gnt: the access still completes and done still pulses; the requester ignores it.
- Request dropped before being sampled: no grant is issued.
- Simultaneous requests: the loser's request is held pending and is granted at the first IDLE edge after the winner's RESP. Under RR_EN=1 no requester waits more than one full transaction.
- Reset asserted mid-ACCESS: the access is abandoned, enables drop immediately (asynchronously), no done is issued, and rr_last returns to 1.
- Address alignment: not checked; addr is passed to memory unchanged. The range check is unsigned 64-bit.

Test Plan:
- Single read (MEM_LATENCY=1): mem_val_read=0x1122334455667788, req=01, we=0, addr0=0x40 -> gnt=01 in cycle 1; mem_reEn=1, mem_addr=0x40 in cycle 1; done=01 in cycle 2 with rdata=0x1122334455667788, err=0.
- Single write: req=10, we=10, addr1=0x8, wdata1=0xDEAD -> gnt=10; one cycle of mem_wrEn=1, mem_val_write=0xDEAD; done=10 with rdata=0, err=0; mem_reEn stays 0 throughout.
- Contention with RR_EN=1, both requesters held high for 4 transactions -> grant order 0,1,0,1; gnt pulses spaced MEM_LATENCY+2 cycles apart. With RR_EN=0 the same stimulus gives grants 0,0,0,0.
- Out-of-range with MEM_BYTES=1024: addr0=0x3F9 -> gnt and done=01 in the same cycle, err=1, rdata=0, no memory enable asserted. addr0=0x3F8 -> normal access, err=0.
- Memory error with MEM_LATENCY=3: mem_error=1 during the read -> three cycles of mem_reEn, then done with err=1.
- Reset during ACCESS with MEM_LATENCY=4: reset asserted 2 cycles after gnt -> mem_reEn falls without waiting for a clock edge; no done is issued. After release, req=11 -> requester 0 is granted first.
